// File: rtl/led_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pkg : mode encodings, pattern FSM states, step-period helper.  rev 1.0
// ---------------------------------------------------------------------------
package led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_BLINK = 3'd1,
    S_CHASE = 3'd2,
    S_BNC_L = 3'd3,
    S_BNC_R = 3'd4
  } state_t;

  // rate 0 is the slowest (8 base periods), rate 3 the fastest (1 base period)
  function automatic logic [31:0] period_of(input logic [1:0] rate, input logic [31:0] base);
    return base << (2'd3 - rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_tick_gen : programmable period divider, wrap is high on the last count.
// rev 1.0
// ---------------------------------------------------------------------------
module led_tick_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             en,
  input  logic             clr,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == period - CNT_W'(1));
  // a clear on the terminal count swallows the wrap
  assign wrap   = en && !clr && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (at_end) cnt <= '0;
      else        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pattern_ctrl : off/blink/chase/bounce LED engine with pause and step.
// rev 1.0
// ---------------------------------------------------------------------------
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int BASE_DIV = 12500000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       rate_sel,
  input  logic             pause,
  input  logic             step,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  logic [1:0]       mode_q;
  logic [1:0]       rate_q;
  state_t           state;
  logic             mode_chg;
  logic             rate_chg;
  logic             wrap;
  logic             adv;
  logic [CNT_W-1:0] period;
  logic [N_LED-1:0] led_shl;
  logic [N_LED-1:0] led_shr;
  logic [N_LED-1:0] led_rol;

  assign period   = CNT_W'(period_of(rate_q, 32'(BASE_DIV)));
  assign mode_chg = (mode != mode_q);
  assign rate_chg = (rate_sel != rate_q);
  // mode change outranks rate change, which outranks any advance
  assign adv      = !mode_chg && !rate_chg && (wrap || (step && pause));

  assign led_shl  = led << 1;
  assign led_shr  = led >> 1;
  assign led_rol  = {led[N_LED-2:0], led[N_LED-1]};

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .en     (!pause),
    .clr    (mode_chg || rate_chg),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      rate_q <= 2'd0;
      state  <= S_OFF;
      led    <= '0;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode;
      rate_q <= rate_sel;
      tick   <= 1'b0;
      if (mode_chg) begin
        case (mode)
          MODE_OFF:   begin led <= '0;          state <= S_OFF;   end
          MODE_BLINK: begin led <= '0;          state <= S_BLINK; end
          MODE_CHASE: begin led <= N_LED'(1);   state <= S_CHASE; end
          default:    begin led <= N_LED'(1);   state <= S_BNC_L; end
        endcase
      end else if (adv) begin
        tick <= 1'b1;
        case (state)
          S_OFF:   led <= '0;
          S_BLINK: led <= ~led;
          S_CHASE: led <= led_rol;
          S_BNC_L: begin
            led <= led_shl;
            if (led_shl[N_LED-1]) state <= S_BNC_R;
          end
          S_BNC_R: begin
            led <= led_shr;
            if (led_shr == N_LED'(1)) state <= S_BNC_L;
          end
          default: begin led <= '0; state <= S_OFF; end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl : directed checks with BASE_DIV=2, N_LED=4.  rev 1.0
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] rate_sel;
  logic       pause;
  logic       step;
  logic [3:0] led;
  logic       tick;

  int total;
  int bad;

  led_pattern_ctrl #(
    .N_LED    (4),
    .BASE_DIV (2),
    .CNT_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .rate_sel (rate_sel),
    .pause    (pause),
    .step     (step),
    .led      (led),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // gap-1 quiet cycles, then one cycle carrying tick and the new pattern
  task automatic expect_adv(input string tag, input int gap, input logic [3:0] exp_led);
    int nt;
    nt = 0;
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      nt += int'(tick);
    end
    chk_val({tag, "_quiet"}, nt, 0);
    @(negedge clk);
    chk_val({tag, "_tick"}, {31'd0, tick}, 1);
    chk_val({tag, "_led"}, {28'd0, led}, {28'd0, exp_led});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int nt;
    int nchg;
    total = 0;
    bad   = 0;
    rst = 1'b1; mode = 2'd1; rate_sel = 2'd0; pause = 1'b0; step = 1'b0;

    repeat (3) @(negedge clk);
    chk_val("reset_led", {28'd0, led}, 0);
    chk_val("reset_tick", {31'd0, tick}, 0);

    // blink at the slowest rate: 16-cycle period
    rst = 1'b0;
    expect_adv("blink1", 17, 4'b1111);
    @(negedge clk);
    chk_val("blink_tick_width", {31'd0, tick}, 0);
    expect_adv("blink2", 15, 4'b0000);

    // chase at the fastest rate
    mode = 2'd2; rate_sel = 2'd3;
    @(negedge clk);
    chk_val("chase_init", {28'd0, led}, 4'b0001);
    expect_adv("chase_a", 2, 4'b0010);
    expect_adv("chase_b", 2, 4'b0100);
    expect_adv("chase_c", 2, 4'b1000);
    expect_adv("chase_d", 2, 4'b0001);

    // bounce reverses without repeating the end value
    mode = 2'd3;
    @(negedge clk);
    chk_val("bnc_init", {28'd0, led}, 4'b0001);
    expect_adv("bnc_a", 2, 4'b0010);
    expect_adv("bnc_b", 2, 4'b0100);
    expect_adv("bnc_c", 2, 4'b1000);
    expect_adv("bnc_d", 2, 4'b0100);
    expect_adv("bnc_e", 2, 4'b0010);
    expect_adv("bnc_f", 2, 4'b0001);
    expect_adv("bnc_g", 2, 4'b0010);

    // pause with the counter held at 1, then single step
    mode = 2'd2;
    @(negedge clk);
    expect_adv("pchase", 2, 4'b0010);
    @(negedge clk);
    pause = 1'b1;
    nt = 0; nchg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nt += int'(tick);
      if (led != 4'b0010) nchg++;
    end
    chk_val("pause_no_tick", nt, 0);
    chk_val("pause_led_frozen", nchg, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk_val("step_led", {28'd0, led}, 4'b0100);
    chk_val("step_tick", {31'd0, tick}, 1);
    @(negedge clk);
    chk_val("step_tick_width", {31'd0, tick}, 0);
    pause = 1'b0;
    @(negedge clk);
    chk_val("resume_tick", {31'd0, tick}, 1);
    chk_val("resume_led", {28'd0, led}, 4'b1000);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk_val("step_unpaused_tick", {31'd0, tick}, 0);
    chk_val("step_unpaused_led", {28'd0, led}, 4'b1000);
    @(negedge clk);
    chk_val("after_step_led", {28'd0, led}, 4'b0001);

    // rate change at counter=10 restarts the count
    rate_sel = 2'd0;
    nt = 0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      nt += int'(tick);
    end
    chk_val("slow_no_tick", nt, 0);
    rate_sel = 2'd3;
    @(negedge clk);
    chk_val("rate_chg_tick", {31'd0, tick}, 0);
    expect_adv("rate_fast", 2, 4'b0010);
    @(negedge clk);
    rate_sel = 2'd2;
    @(negedge clk);
    chk_val("wrap_dropped_tick", {31'd0, tick}, 0);
    chk_val("wrap_dropped_led", {28'd0, led}, 4'b0010);
    expect_adv("rate_mid", 4, 4'b0100);

    // mode change on the wrap edge: init pattern wins
    repeat (3) @(negedge clk);
    mode = 2'd1;
    @(negedge clk);
    chk_val("mode_wins_led", {28'd0, led}, 4'b0000);
    chk_val("mode_wins_tick", {31'd0, tick}, 0);

    // asynchronous reset mid-bounce
    mode = 2'd3; rate_sel = 2'd3;
    @(negedge clk);
    chk_val("bnc2_init", {28'd0, led}, 4'b0001);
    expect_adv("bnc2_a", 2, 4'b0010);
    expect_adv("bnc2_b", 2, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk_val("async_rst_led", {28'd0, led}, 0);
    chk_val("async_rst_tick", {31'd0, tick}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_val("post_rst_init", {28'd0, led}, 4'b0001);
    expect_adv("post_rst_a", 2, 4'b0010);
    expect_adv("post_rst_b", 2, 4'b0100);
    expect_adv("post_rst_c", 2, 4'b1000);
    expect_adv("post_rst_d", 2, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised LED pattern engine for board LED banks. It replaces the fixed single-rate blinker with four selectable step rates and four display modes: off, blink, chase and bounce. It also provides pause and single-step control. It sits between the board switch/button debouncers and the LED pins, and exports a step strobe for other blocks.

Parameters:
N_LED, 16, number of LEDs driven; legal range 2..32.
BASE_DIV, 12500000, clock cycles per 1/8 s at 100 MHz; minimum 1.
CNT_W, 32, width of the internal period counter; must hold 8*BASE_DIV-1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
mode  input  2  0=OFF, 1=BLINK, 2=CHASE, 3=BOUNCE; level, already synchronised
rate_sel  input  2  step period = BASE_DIV << (3-rate_sel) cycles (0:1 s, 1:0.5 s, 2:0.25 s, 3:0.125 s)
pause  input  1  level; high freezes the period counter and the pattern
step  input  1  one-cycle pulse; advances the pattern once, only while pause=1
led  output  N_LED  LED pattern, registered
tick  output  1  one-cycle pulse, high in the first cycle a new pattern is shown

Behaviour:
- Reset values: led=0, tick=0, counter=0, mode_q=0, rate_q=0, state=S_OFF, dir=left.
- Period: P = BASE_DIV << (3-rate_q).
- Counter: increments each cycle while pause=0. At counter==P-1 the next edge does three things: counter<=0, led<=next pattern, tick<=1.
- An advance from a period wrap or from a step always produces exactly one tick pulse.
- Counter arithmetic is unsigned CNT_W. The counter never exceeds P-1; the wrap compare uses ==.
- FSM states: S_OFF, S_BLINK, S_CHASE, S_BNC_L, S_BNC_R.
- mode_q/rate_q register mode/rate_sel each cycle. A change is detected as mode!=mode_q (or rate_sel!=rate_q) and takes effect on that edge.
- Mode change, on the edge where mode!=mode_q:
  - counter<=0 and tick<=0.
  - Pattern is initialised: OFF led=0; BLINK led=0; CHASE led=1 (LSB); BOUNCE led=1, state S_BNC_L.
- Advances per mode:
  - S_OFF: led stays 0. Ticks still occur so the strobe stays usable.
  - S_BLINK: led <= ~led. All bits always equal.
  - S_CHASE: rotate left by 1; MSB wraps to LSB.
  - S_BNC_L: shift left. If the new value has the MSB set, go to S_BNC_R.
  - S_BNC_R: shift right. If the new value equals 1, go to S_BNC_L.
  - Bounce is never stuck at an end: N_LED=4 gives 0001,0010,0100,1000,0100,0010,0001,0010...
- Rate change (rate_sel!=rate_q): counter<=0, pattern and state kept, no tick that cycle.
- Pause=1: counter holds its value, no period ticks. Releasing pause resumes counting from the held value.
- Step: honoured only when pause=1. It causes one advance plus tick on the next edge; step while pause=0 is ignored.
- Priority on the same edge, highest first: reset > mode change > rate change > step/period advance.
  - Step coincident with a mode change is dropped.
  - A period wrap coincident with a rate change is dropped (counter restarts).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). After release the pattern resumes from OFF until mode_q captures the input; that capture counts as a mode change if mode!=0.
- Held inputs (step, pause, mode, rate_sel) are not debounced here; the caller provides clean signals.

Decomposition:
- Package led_pkg: mode encoding constants, FSM state typedef, and a function period_of(rate, base) returning BASE_DIV << (3-rate).
- Sub-module led_tick_gen: programmable divider with inputs period, en (=~pause), clr (mode/rate change) and output wrap.
- The pattern FSM, step logic and output registers stay in led_pattern_ctrl.

Test Plan:
Bench parameters BASE_DIV=2, N_LED=4.
- Reset, mode=1, rate_sel=0, pause=0 -> led=0000 until first tick 16 cycles after mode capture, then 1111, 0000 every 16 cycles; tick is exactly 1 cycle wide.
- mode=2, rate_sel=3 -> led 0001,0010,0100,1000,0001 every 2 cycles; tick on every change.
- mode=3, rate_sel=3 -> 0001,0010,0100,1000,0100,0010,0001,0010; no repeated end value.
- CHASE at led=0010, pause=1 for 40 cycles -> led and counter frozen, no tick; step pulse -> 0100 plus tick next edge; step with pause=0 -> no extra advance.
- rate_sel 0->3 at counter=10 -> counter cleared, no tick that cycle, next advance 2 cycles later; mode change on the wrap cycle -> init pattern wins, no advance.
- Assert rst mid-BOUNCE at led=0100 -> led=0000 and tick=0 asynchronously; after release the sequence restarts at 0001 with direction left.
